// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder-buffer widths and entry record
package rob_pkg;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 2;
  localparam int REG_W  = 2;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] val;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrapping head/tail pointers and occupancy count
module rob_ptr
  import rob_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc_head,
  input  logic             i_inc_tail,
  output logic [TAG_W-1:0] o_head,
  output logic [TAG_W-1:0] o_tail,
  output logic [TAG_W:0]   o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  always_comb begin
    head_d  = i_inc_head ? head_q + TAG_W'(1) : head_q;
    tail_d  = i_inc_tail ? tail_q + TAG_W'(1) : tail_q;
    count_d = count_q;
    if (i_inc_tail && !i_inc_head)
      count_d = count_q + (TAG_W+1)'(1);
    else if (i_inc_head && !i_inc_tail)
      count_d = count_q - (TAG_W+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_head  = head_q;
  assign o_tail  = tail_q;
  assign o_count = count_q;
  assign o_full  = (count_q == (TAG_W+1)'(DEPTH));
  assign o_empty = (count_q == '0);
endmodule

// File: rtl/rob_ctrl.sv
// rtl/rob_ctrl.sv - four-entry reorder buffer: allocate, writeback, in-order retire
module rob_ctrl
  import rob_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alloc_valid,
  input  logic [REG_W-1:0]  i_alloc_dst_addr,
  output logic              o_alloc_ready,
  output logic              o_rat_valid,
  output logic [TAG_W-1:0]  o_rat_rob_addr,
  output logic [REG_W-1:0]  o_rat_dst_addr,
  input  logic              i_wb_valid,
  input  logic [TAG_W-1:0]  i_wb_rob_addr,
  input  logic [DATA_W-1:0] i_wb_val,
  output logic              o_commit_valid,
  output logic [TAG_W-1:0]  o_commit_rob_addr,
  output logic [REG_W-1:0]  o_commit_dst_addr,
  output logic [DATA_W-1:0] o_commit_val,
  input  logic [TAG_W-1:0]  i_rd_addr,
  output logic              o_rd_ready,
  output logic [DATA_W-1:0] o_rd_val
);
  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic              commit_valid_q, commit_valid_d;
  logic [TAG_W-1:0]  commit_rob_q, commit_rob_d;
  logic [REG_W-1:0]  commit_dst_q, commit_dst_d;
  logic [DATA_W-1:0] commit_val_q, commit_val_d;

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic             full, empty;
  logic             alloc_fire, commit_fire, wb_fire;

  rob_ptr u_ptr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc_head (commit_fire),
    .i_inc_tail (alloc_fire),
    .o_head     (head),
    .o_tail     (tail),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty)
  );

  assign alloc_fire  = i_alloc_valid & ~full;
  assign commit_fire = ~empty & entries_q[head].busy & entries_q[head].done;
  assign wb_fire     = i_wb_valid & entries_q[i_wb_rob_addr].busy & ~entries_q[i_wb_rob_addr].done;

  // Commit, alloc and writeback always touch distinct entries: the head is
  // done (writeback ignored) and the tail is free whenever alloc fires.
  always_comb begin
    entries_d = entries_q;
    if (commit_fire) begin
      entries_d[head].busy = 1'b0;
      entries_d[head].done = 1'b0;
    end
    if (alloc_fire) begin
      entries_d[tail].busy = 1'b1;
      entries_d[tail].done = 1'b0;
      entries_d[tail].dst  = i_alloc_dst_addr;
    end
    if (wb_fire) begin
      entries_d[i_wb_rob_addr].done = 1'b1;
      entries_d[i_wb_rob_addr].val  = i_wb_val;
    end
    commit_valid_d = commit_fire;
    commit_rob_d   = commit_fire ? head : '0;
    commit_dst_d   = commit_fire ? entries_q[head].dst : '0;
    commit_val_d   = commit_fire ? entries_q[head].val : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      commit_valid_q <= 1'b0;
      commit_rob_q   <= '0;
      commit_dst_q   <= '0;
      commit_val_q   <= '0;
    end else begin
      entries_q      <= entries_d;
      commit_valid_q <= commit_valid_d;
      commit_rob_q   <= commit_rob_d;
      commit_dst_q   <= commit_dst_d;
      commit_val_q   <= commit_val_d;
    end
  end

  assign o_alloc_ready     = ~full;
  assign o_rat_valid       = alloc_fire;
  assign o_rat_rob_addr    = tail;
  assign o_rat_dst_addr    = i_alloc_dst_addr;
  assign o_commit_valid    = commit_valid_q;
  assign o_commit_rob_addr = commit_rob_q;
  assign o_commit_dst_addr = commit_dst_q;
  assign o_commit_val      = commit_val_q;
  assign o_rd_ready        = entries_q[i_rd_addr].busy & entries_q[i_rd_addr].done;
  assign o_rd_val          = entries_q[i_rd_addr].val;
endmodule

// File: tb/tb_rob_ctrl.sv
// tb/tb_rob_ctrl.sv - directed vector bench for rob_ctrl
module tb_rob_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [1:0]  alloc_dst;
  logic        alloc_ready;
  logic        rat_valid;
  logic [1:0]  rat_tag;
  logic [1:0]  rat_dst;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [15:0] wb_val;
  logic        commit_valid;
  logic [1:0]  commit_tag;
  logic [1:0]  commit_dst;
  logic [15:0] commit_val;
  logic [1:0]  rd_addr;
  logic        rd_ready;
  logic [15:0] rd_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_ctrl dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_alloc_valid     (alloc_valid),
    .i_alloc_dst_addr  (alloc_dst),
    .o_alloc_ready     (alloc_ready),
    .o_rat_valid       (rat_valid),
    .o_rat_rob_addr    (rat_tag),
    .o_rat_dst_addr    (rat_dst),
    .i_wb_valid        (wb_valid),
    .i_wb_rob_addr     (wb_addr),
    .i_wb_val          (wb_val),
    .o_commit_valid    (commit_valid),
    .o_commit_rob_addr (commit_tag),
    .o_commit_dst_addr (commit_dst),
    .o_commit_val      (commit_val),
    .i_rd_addr         (rd_addr),
    .o_rd_ready        (rd_ready),
    .o_rd_val          (rd_val)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [1:0]  adst;
    logic        wv;
    logic [1:0]  wa;
    logic [15:0] wval;
    logic [1:0]  ra;
    logic        e_ready;
    logic        e_rv;
    logic [1:0]  e_rtag;
    logic [1:0]  e_rdst;
    logic        e_cv;
    logic [1:0]  e_ctag;
    logic [1:0]  e_cdst;
    logic [15:0] e_cval;
    logic        e_rdy;
    logic        chk_rdv;
    logic [15:0] e_rdv;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [1:0] ad, input logic wv,
                       input logic [1:0] wa, input logic [15:0] wd, input logic [1:0] ra);
    rst = r; alloc_valid = av; alloc_dst = ad;
    wb_valid = wv; wb_addr = wa; wb_val = wd; rd_addr = ra;
  endtask

  initial begin
    // rst av adst wv wa wval ra | ready rv rtag rdst | cv ctag cdst cval | rdy chk rdv
    vq.push_back('{1'b0,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b1,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd2,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b1,2'd0,2'd2, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b1,16'h0000});
    vq.push_back('{1'b1,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd0,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b1,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd1,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b1,2'd1,2'd1, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd2,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b1,2'd2,2'd2, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd3,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b1,2'd3,2'd3, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd1,1'b1,2'd1,16'h0011,2'd0, 1'b0,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b0,2'd0,1'b1,2'd0,16'h0022,2'd1, 1'b0,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b1,1'b1,16'h0011});
    vq.push_back('{1'b0,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd0, 1'b0,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b1,1'b1,16'h0022});
    vq.push_back('{1'b0,1'b0,2'd0,1'b1,2'd2,16'h00AB,2'd2, 1'b1,1'b0,2'd0,2'd0, 1'b1,2'd0,2'd0,16'h0022, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd2, 1'b1,1'b0,2'd0,2'd0, 1'b1,2'd1,2'd1,16'h0011, 1'b1,1'b1,16'h00AB});
    vq.push_back('{1'b0,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd3, 1'b1,1'b0,2'd0,2'd0, 1'b1,2'd2,2'd2,16'h00AB, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd0,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b1,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd1,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b1,2'd1,2'd1, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd2,1'b1,2'd3,16'h0033,2'd0, 1'b1,1'b1,2'd2,2'd2, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd0,1'b0,2'd0,16'h0000,2'd3, 1'b0,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b1,1'b1,16'h0033});
    vq.push_back('{1'b0,1'b1,2'd0,1'b1,2'd0,16'h0044,2'd3, 1'b1,1'b1,2'd3,2'd0, 1'b1,2'd3,2'd3,16'h0033, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd0, 1'b0,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b1,1'b1,16'h0044});
    vq.push_back('{1'b0,1'b0,2'd0,1'b1,2'd2,16'h0055,2'd1, 1'b1,1'b0,2'd0,2'd0, 1'b1,2'd0,2'd0,16'h0044, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b1,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd2, 1'b1,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b1,1'b1,16'h0055});
    vq.push_back('{1'b0,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd2, 1'b1,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b1,16'h0000});
    vq.push_back('{1'b0,1'b1,2'd3,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b1,2'd0,2'd3, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});
    vq.push_back('{1'b0,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd0, 1'b1,1'b0,2'd0,2'd0, 1'b0,2'd0,2'd0,16'h0000, 1'b0,1'b0,16'h0000});

    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0, 2'd0);
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].av, vq[i].adst, vq[i].wv, vq[i].wa, vq[i].wval, vq[i].ra);
      #1;
      chk($sformatf("r%0d alloc_ready", i), 16'(alloc_ready), 16'(vq[i].e_ready));
      chk($sformatf("r%0d rat_valid", i), 16'(rat_valid), 16'(vq[i].e_rv));
      if (vq[i].e_rv) begin
        chk($sformatf("r%0d rat_tag", i), 16'(rat_tag), 16'(vq[i].e_rtag));
        chk($sformatf("r%0d rat_dst", i), 16'(rat_dst), 16'(vq[i].e_rdst));
      end
      chk($sformatf("r%0d commit_valid", i), 16'(commit_valid), 16'(vq[i].e_cv));
      if (vq[i].e_cv) begin
        chk($sformatf("r%0d commit_tag", i), 16'(commit_tag), 16'(vq[i].e_ctag));
        chk($sformatf("r%0d commit_dst", i), 16'(commit_dst), 16'(vq[i].e_cdst));
        chk($sformatf("r%0d commit_val", i), commit_val, vq[i].e_cval);
      end
      chk($sformatf("r%0d rd_ready", i), 16'(rd_ready), 16'(vq[i].e_rdy));
      if (vq[i].chk_rdv)
        chk($sformatf("r%0d rd_val", i), rd_val, vq[i].e_rdv);
    end

    // Writeback to head: pulse two cycles later, once, ignoring a late duplicate.
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 16'h0099, 2'd0);
    #1 chk("lat n commit_valid", 16'(commit_valid), 16'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 16'h1234, 2'd0);
    #1 chk("lat n+1 commit_valid", 16'(commit_valid), 16'd0);
    chk("lat n+1 rd_val", rd_val, 16'h0099);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 2'd0);
    #1 chk("lat n+2 commit_valid", 16'(commit_valid), 16'd1);
    chk("lat n+2 commit_tag", 16'(commit_tag), 16'd0);
    chk("lat n+2 commit_dst", 16'(commit_dst), 16'd3);
    chk("lat n+2 commit_val", commit_val, 16'h0099);
    @(negedge clk);
    #1 chk("lat n+3 commit_valid", 16'(commit_valid), 16'd0);
    chk("lat n+3 alloc_ready", 16'(alloc_ready), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
